// File: rtl/mul_seq_gen_pkg.sv
// Shared types and elaboration helpers for the multiplier-sequence generator.
package mul_seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PREP = 2'd2
  } state_e;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/mul_seq_gen_offs.sv
// Lane offset table X*0..X*(LANES-1) plus beat stride X*LANES, multiplier-free:
// power-of-two lanes are pure shifts, the rest add X to the previous lane.
module mul_seq_gen_offs
  import mul_seq_gen_pkg::*;
#(
  parameter int DATA_IN_W  = 8,
  parameter int DATA_OUT_W = 13,
  parameter int LANES      = 4
) (
  input  logic [DATA_IN_W-1:0]              base,
  output logic [LANES-1:0][DATA_OUT_W-1:0]  offs,
  output logic [DATA_OUT_W-1:0]             step
);

  logic [DATA_OUT_W-1:0] base_ext;
  assign base_ext = DATA_OUT_W'(base);

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    if (j == 0) begin : g_zero
      assign offs[j] = '0;
    end else if (is_pow2(j)) begin : g_shift
      assign offs[j] = base_ext << $clog2(j);
    end else begin : g_add
      assign offs[j] = offs[j-1] + base_ext;
    end
  end

  if (is_pow2(LANES)) begin : g_step_shift
    assign step = base_ext << $clog2(LANES);
  end else begin : g_step_add
    assign step = offs[LANES-1] + base_ext;
  end

endmodule

// File: rtl/mul_seq_gen.sv
// Streaming multi-lane generator of X*k sequences (one accumulator + offset table).
// Optional start index behind `MUL_SEQ_GEN_START_EN` (adds cmd_start and a PREP state).
module mul_seq_gen
  import mul_seq_gen_pkg::*;
#(
  parameter int DATA_IN_W   = 8,
  parameter int SEQ_LEN_MAX = 32,
  parameter int LANES       = 4,
  parameter int LEN_W       = $clog2(SEQ_LEN_MAX + 1),
  parameter int DATA_OUT_W  = DATA_IN_W + $clog2(SEQ_LEN_MAX)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [DATA_IN_W-1:0]             cmd_base,
  input  logic [LEN_W-1:0]                 cmd_len,
`ifdef MUL_SEQ_GEN_START_EN
  input  logic [LEN_W-1:0]                 cmd_start,
`endif
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES-1:0][DATA_OUT_W-1:0] out_data,
  output logic [LANES-1:0]                 out_mask,
  output logic                             out_last
);

`ifdef MUL_SEQ_GEN_START_EN
  localparam state_e LOAD_ST = PREP;
`else
  localparam state_e LOAD_ST = RUN;
`endif
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(SEQ_LEN_MAX);
  localparam logic [LEN_W-1:0] LANES_L = LEN_W'(LANES);

  state_e                           state_q, state_d;
  logic [DATA_OUT_W-1:0]            acc_q, acc_d, step_q, step_d, step_w;
  logic [LEN_W-1:0]                 rem_q, rem_d, len_sat, n_eff;
  logic [LANES-1:0][DATA_OUT_W-1:0] offs_q, offs_d, offs_w;
  logic                             run, beat_hs, last_hs, cmd_acc, load;
`ifdef MUL_SEQ_GEN_START_EN
  logic [LEN_W-1:0]                 start_q, start_d, cnt_q, cnt_d, avail;
  logic [DATA_IN_W-1:0]             base_q, base_d;
`endif

  mul_seq_gen_offs #(
    .DATA_IN_W (DATA_IN_W),
    .DATA_OUT_W(DATA_OUT_W),
    .LANES     (LANES)
  ) u_offs (
    .base(cmd_base),
    .offs(offs_w),
    .step(step_w)
  );

  // Effective element count after saturation (and start-index clamping).
  always_comb begin
    len_sat = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
    n_eff   = len_sat;
`ifdef MUL_SEQ_GEN_START_EN
    avail = '0;
    if (cmd_start >= LEN_MAX) begin
      n_eff = '0;
    end else begin
      avail = LEN_MAX - cmd_start;
      n_eff = (len_sat > avail) ? avail : len_sat;
    end
`endif
  end

  assign run     = (state_q == RUN);
  assign beat_hs = run && out_ready;
  assign last_hs = beat_hs && out_last;
  assign cmd_acc = cmd_valid && cmd_ready;
  assign load    = cmd_acc && (n_eff != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      step_q  <= '0;
      rem_q   <= '0;
      offs_q  <= '0;
`ifdef MUL_SEQ_GEN_START_EN
      start_q <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      rem_q   <= rem_d;
      offs_q  <= offs_d;
`ifdef MUL_SEQ_GEN_START_EN
      start_q <= start_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (load) state_d = LOAD_ST;
      RUN:  if (last_hs) state_d = load ? LOAD_ST : IDLE;
`ifdef MUL_SEQ_GEN_START_EN
      PREP: if (cnt_q == '0) state_d = RUN;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Accept and beat advance are exclusive: cmd_ready is only high in RUN on the last beat.
  always_comb begin
    acc_d   = acc_q;
    step_d  = step_q;
    rem_d   = rem_q;
    offs_d  = offs_q;
`ifdef MUL_SEQ_GEN_START_EN
    start_d = start_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
`endif
    if (load) begin
      acc_d  = '0;
      step_d = step_w;
      rem_d  = n_eff;
      offs_d = offs_w;
`ifdef MUL_SEQ_GEN_START_EN
      start_d = cmd_start;
      cnt_d   = LEN_W'(LEN_W - 1);
      base_d  = cmd_base;
`endif
    end else if (last_hs) begin
      acc_d = '0;
      rem_d = '0;
    end else if (beat_hs) begin
      acc_d = acc_q + step_q;
      rem_d = rem_q - LANES_L;
    end
`ifdef MUL_SEQ_GEN_START_EN
    // MSB-first shift-add builds X*S one bit per cycle.
    else if (state_q == PREP) begin
      acc_d = (acc_q << 1) + (start_q[cnt_q] ? DATA_OUT_W'(base_q) : '0);
      cnt_d = cnt_q - 1'b1;
    end
`endif
  end

  always_comb begin
    out_valid = run;
    out_last  = run && (rem_q <= LANES_L);
    for (int j = 0; j < LANES; j++) begin
      out_mask[j] = run && (LEN_W'(j) < rem_q);
      out_data[j] = out_mask[j] ? (acc_q + offs_q[j]) : '0;
    end
    cmd_ready = rst_n && ((state_q == IDLE) || last_hs);
  end

endmodule

// File: tb/tb_mul_seq_gen.sv
// Directed self-checking bench for mul_seq_gen in its default configuration.
module tb_mul_seq_gen;

  localparam int DATA_IN_W   = 8;
  localparam int SEQ_LEN_MAX = 32;
  localparam int LANES       = 4;
  localparam int LEN_W       = 6;
  localparam int DATA_OUT_W  = 13;

  logic                             clk = 1'b0;
  logic                             rst_n = 1'b0;
  logic                             cmd_valid, cmd_ready, out_valid, out_ready, out_last;
  logic [DATA_IN_W-1:0]             cmd_base;
  logic [LEN_W-1:0]                 cmd_len;
  logic [LANES-1:0][DATA_OUT_W-1:0] out_data;
  logic [LANES-1:0]                 out_mask;

  int checks = 0;
  int errors = 0;

  mul_seq_gen #(
    .DATA_IN_W  (DATA_IN_W),
    .SEQ_LEN_MAX(SEQ_LEN_MAX),
    .LANES      (LANES),
    .LEN_W      (LEN_W),
    .DATA_OUT_W (DATA_OUT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_base (cmd_base),
    .cmd_len  (cmd_len),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_mask (out_mask),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] lanes4(input int a, input int b, input int c, input int d);
    logic [51:0] r;
    r = {13'(d), 13'(c), 13'(b), 13'(a)};
    return 64'(r);
  endfunction

  task automatic chk_beat(input string tag, input logic [63:0] data, input logic [3:0] mask,
                          input logic last);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".data"}, 64'(out_data), data);
    chk({tag, ".mask"}, 64'(out_mask), 64'(mask));
    chk({tag, ".last"}, 64'(out_last), 64'(last));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".data"}, 64'(out_data), 64'd0);
    chk({tag, ".mask"}, 64'(out_mask), 64'd0);
    chk({tag, ".last"}, 64'(out_last), 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int beats;
    cmd_valid = 1'b0;
    cmd_base  = '0;
    cmd_len   = '0;
    out_ready = 1'b1;

    // Reset state
    #2;
    chk("rst.cmd_ready", 64'(cmd_ready), 64'd0);
    chk_idle("rst");
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel.cmd_ready", 64'(cmd_ready), 64'd1);
    chk_idle("rel");

    // X=5, N=8
    cmd_valid = 1'b1; cmd_base = 8'd5; cmd_len = 6'd8;
    #1;
    chk("x5.pre_valid", 64'(out_valid), 64'd0);
    tick();
    cmd_valid = 1'b0;
    #1;
    chk_beat("x5.b0", lanes4(0, 5, 10, 15), 4'b1111, 1'b0);
    chk("x5.b0.cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
    chk_beat("x5.b1", lanes4(20, 25, 30, 35), 4'b1111, 1'b1);
    chk("x5.b1.cmd_ready", 64'(cmd_ready), 64'd1);
    tick();
    chk_idle("x5.done");

    // X=3, N=6: partial final beat
    cmd_valid = 1'b1; cmd_base = 8'd3; cmd_len = 6'd6;
    tick();
    cmd_valid = 1'b0;
    #1;
    chk_beat("x3.b0", lanes4(0, 3, 6, 9), 4'b1111, 1'b0);
    tick();
    chk_beat("x3.b1", lanes4(12, 15, 0, 0), 4'b0011, 1'b1);
    tick();
    chk_idle("x3.done");

    // X=255, N=32: widest values
    cmd_valid = 1'b1; cmd_base = 8'd255; cmd_len = 6'd32;
    tick();
    cmd_valid = 1'b0;
    #1;
    for (int b = 0; b < 7; b++) begin
      chk("x255.lane0", 64'(out_data[0]), 64'(255 * 4 * b));
      chk("x255.last", 64'(out_last), 64'd0);
      tick();
    end
    chk_beat("x255.b7", lanes4(7140, 7395, 7650, 7905), 4'b1111, 1'b1);
    tick();
    chk_idle("x255.done");

    // Length saturation: 50 -> 32 elements, 8 beats
    cmd_valid = 1'b1; cmd_base = 8'd1; cmd_len = 6'd50;
    tick();
    cmd_valid = 1'b0;
    beats = 0;
    for (int c = 0; c < 20 && out_valid; c++) begin
      beats++;
      if (out_last) chk_beat("sat.last", lanes4(28, 29, 30, 31), 4'b1111, 1'b1);
      tick();
    end
    chk("sat.beats", 64'(beats), 64'd8);

    // Back-to-back A then B, then N=0 at B's last handshake
    cmd_valid = 1'b1; cmd_base = 8'd1; cmd_len = 6'd4;
    tick();
    cmd_base = 8'd2; cmd_len = 6'd4;
    #1;
    chk_beat("b2b.a", lanes4(0, 1, 2, 3), 4'b1111, 1'b1);
    chk("b2b.a.cmd_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_base = 8'd9; cmd_len = 6'd0;
    #1;
    chk_beat("b2b.b", lanes4(0, 2, 4, 6), 4'b1111, 1'b1);
    tick();
    cmd_valid = 1'b0;
    #1;
    chk_idle("b2b.n0");
    chk("b2b.n0.cmd_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    #1;
    chk_idle("idle.n0");

    // Backpressure mid-command and on the last beat
    cmd_valid = 1'b1; cmd_base = 8'd7; cmd_len = 6'd12;
    tick();
    cmd_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      chk_beat("bp.hold", lanes4(0, 7, 14, 21), 4'b1111, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk_beat("bp.b0", lanes4(0, 7, 14, 21), 4'b1111, 1'b0);
    tick();
    chk_beat("bp.b1", lanes4(28, 35, 42, 49), 4'b1111, 1'b0);
    tick();
    out_ready = 1'b0;
    #1;
    chk_beat("bp.b2", lanes4(56, 63, 70, 77), 4'b1111, 1'b1);
    chk("bp.b2.cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
    chk_beat("bp.b2.hold", lanes4(56, 63, 70, 77), 4'b1111, 1'b1);
    out_ready = 1'b1;
    tick();
    chk_idle("bp.done");

    // Reset during beat 2 of an N=32 command
    cmd_valid = 1'b1; cmd_base = 8'd2; cmd_len = 6'd32;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk_beat("rmid.b1", lanes4(8, 10, 12, 14), 4'b1111, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_idle("rmid.async");
    chk("rmid.cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rmid.rel.cmd_ready", 64'(cmd_ready), 64'd1);
    tick();
    chk_idle("rmid.after");
    tick();
    chk_idle("rmid.after2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
